// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage; assembles 32-bit little-endian words from a byte-wide port.
// Optional direct-mapped instruction cache is built when IF_ICACHE_EN is defined.
module if_fetch #(
    parameter int ICACHE_IDX_W = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall_hold,
    input  logic        br_taken,
    input  logic [16:0] br_addr,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din,
    output logic        mem_req,
    output logic [16:0] mem_addr,
    output logic [16:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_stall_req
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [16:0] pc;
    logic [2:0]  issue_cnt;
    logic [2:0]  recv_cnt;
    logic        byte_pend;
    logic [7:0]  byte_buf [4];
    logic [31:0] word;
    logic        grant_ok;
    logic        last_byte;
    logic        hit;

    assign word      = {byte_buf[3], byte_buf[2], byte_buf[1], byte_buf[0]};
    assign grant_ok  = mem_req && mem_grant;
    assign last_byte = byte_pend && (recv_cnt == 3'd3);

`ifdef IF_ICACHE_EN
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 15 - ICACHE_IDX_W;

    logic [31:0]             cache_data [LINES];
    logic [TAG_W-1:0]        cache_tag  [LINES];
    logic [LINES-1:0]        cache_vld;
    logic [ICACHE_IDX_W-1:0] idx;
    logic                    fetch_first;
    logic [31:0]             hit_word;

    assign idx         = pc[ICACHE_IDX_W+1:2];
    assign fetch_first = (state == FETCH) && (issue_cnt == 3'd0) && (recv_cnt == 3'd0) && !byte_pend;
    assign hit         = fetch_first && cache_vld[idx] && (cache_tag[idx] == pc[16:ICACHE_IDX_W+2]);
    assign hit_word    = cache_data[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld <= '0;
        end else if (rdy && state == DONE) begin
            cache_vld[idx] <= 1'b1;
        end
    end

    // Fill with whatever word DONE holds; a hit rewrites the identical value.
    always_ff @(posedge clk) begin
        if (rdy && state == DONE) begin
            cache_data[idx] <= word;
            cache_tag[idx]  <= pc[16:ICACHE_IDX_W+2];
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (br_taken) begin
            state_nx = FETCH;
        end else begin
            case (state)
                IDLE:    state_nx = FETCH;
                FETCH:   if (hit || recv_cnt[2] || last_byte) state_nx = DONE;
                DONE:    if (!stall_hold) state_nx = FETCH;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        if_inst      = 32'd0;
        if_stall_req = 1'b1;
        case (state)
            FETCH:   mem_req = rdy && !issue_cnt[2] && !hit;
            DONE: begin
                if_inst      = word;
                if_stall_req = 1'b0;
            end
            default: ;
        endcase
    end

    assign mem_addr = pc + {14'd0, issue_cnt};
    assign if_pc    = pc;

    // A byte granted last cycle lands even while frozen; a redirect drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= 17'd0;
            issue_cnt <= 3'd0;
            recv_cnt  <= 3'd0;
            byte_pend <= 1'b0;
            for (int i = 0; i < 4; i++) byte_buf[i] <= 8'd0;
        end else begin
            if (byte_pend) begin
                byte_buf[recv_cnt[1:0]] <= mem_din;
                recv_cnt                <= recv_cnt + 3'd1;
            end
            byte_pend <= grant_ok;
            if (rdy) begin
                if (grant_ok) issue_cnt <= issue_cnt + 3'd1;
                if (br_taken) begin
                    pc        <= br_addr;
                    issue_cnt <= 3'd0;
                    recv_cnt  <= 3'd0;
                    byte_pend <= 1'b0;
                end else if (state == DONE && !stall_hold) begin
                    pc        <= pc + 17'd4;
                    issue_cnt <= 3'd0;
                    recv_cnt  <= 3'd0;
`ifdef IF_ICACHE_EN
                end else if (hit) begin
                    for (int i = 0; i < 4; i++) byte_buf[i] <= hit_word[8*i +: 8];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios for if_fetch against a byte-wide memory model.
// The cache scenario is compiled only when IF_ICACHE_EN is defined.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst, rdy, stall_hold, br_taken, mem_grant;
    logic [16:0] br_addr;
    logic [7:0]  mem_din;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic [16:0] if_pc;
    logic [31:0] if_inst;
    logic        if_stall_req;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall_hold(stall_hold),
        .br_taken(br_taken), .br_addr(br_addr), .mem_grant(mem_grant), .mem_din(mem_din),
        .mem_req(mem_req), .mem_addr(mem_addr), .if_pc(if_pc), .if_inst(if_inst),
        .if_stall_req(if_stall_req)
    );

    // Addresses 0..3 hold ADDI x0,x0,5; elsewhere byte = addr[7:0] + 0x5A.
    function automatic logic [7:0] mem_byte(input logic [16:0] a);
        case (a)
            17'd0:   mem_byte = 8'h13;
            17'd1:   mem_byte = 8'h00;
            17'd2:   mem_byte = 8'h50;
            17'd3:   mem_byte = 8'h00;
            default: mem_byte = a[7:0] + 8'h5A;
        endcase
    endfunction

    always @(posedge clk) mem_din <= (mem_req && mem_grant) ? mem_byte(mem_addr) : 8'hEE;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rdy = 1'b1; stall_hold = 1'b0; br_taken = 1'b0; br_addr = 17'd0; mem_grant = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_word(input int budget);
        int n = 0;
        while (if_stall_req !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (if_stall_req !== 1'b0) begin
            errors++;
            $display("FAIL wait_word: if_stall_req=%b after %0d cycles, want 0", if_stall_req, budget);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; rdy = 1'b1; stall_hold = 1'b0; br_taken = 1'b0; br_addr = 17'd0; mem_grant = 1'b1;
        @(negedge clk);
        checks++; if (if_pc !== 17'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc); end
        checks++; if (if_inst !== 32'd0) begin errors++; $display("FAIL reset_inst: got %h want 0", if_inst); end
        checks++; if (if_stall_req !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b want 1", if_stall_req); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 17'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        br_taken = 1'b1; br_addr = 17'h00100;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr} !== 18'd0) begin
            errors++; $display("FAIL reset_over_br: req=%b addr=%h want 0/0", mem_req, mem_addr);
        end
        br_taken = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, if_stall_req} !== {1'b0, 17'd0, 1'b1}) begin
            errors++; $display("FAIL midreset_state: req=%b addr=%h stall=%b want 0/0/1", mem_req, mem_addr, if_stall_req);
        end
        rst = 1'b0;
        wait_word(10);
        checks++;
        if ({if_pc, if_inst} !== {17'd0, 32'h00500013}) begin
            errors++; $display("FAIL midreset_word: pc=%h inst=%h want 0/00500013", if_pc, if_inst);
        end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, 17'(i)}) begin
                errors++; $display("FAIL basic_addr%0d: req=%b addr=%h want 1/%h", i, mem_req, mem_addr, i);
            end
        end
        @(negedge clk);
        checks++;
        if ({mem_req, if_stall_req, if_inst} !== {1'b0, 1'b1, 32'd0}) begin
            errors++; $display("FAIL basic_bubble: req=%b stall=%b inst=%h want 0/1/0", mem_req, if_stall_req, if_inst);
        end
        @(negedge clk);
        checks++;
        if ({if_stall_req, if_pc, if_inst} !== {1'b0, 17'd0, 32'h00500013}) begin
            errors++; $display("FAIL basic_word: stall=%b pc=%h inst=%h want 0/0/00500013", if_stall_req, if_pc, if_inst);
        end
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, if_stall_req} !== {1'b1, 17'd4, 1'b1}) begin
            errors++; $display("FAIL basic_next: req=%b addr=%h stall=%b want 1/4/1", mem_req, mem_addr, if_stall_req);
        end
    endtask

    task automatic test_grant_gaps();
        logic        g [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [16:0] a [6] = '{17'd0, 17'd1, 17'd1, 17'd1, 17'd2, 17'd3};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, a[i]}) begin
                errors++; $display("FAIL gap_addr%0d: req=%b addr=%h want 1/%h", i, mem_req, mem_addr, a[i]);
            end
            mem_grant = g[i];
        end
        @(negedge clk);
        checks++;
        if ({mem_req, if_stall_req} !== 2'b01) begin
            errors++; $display("FAIL gap_wait: req=%b stall=%b want 0/1", mem_req, if_stall_req);
        end
        @(negedge clk);
        checks++;
        if ({if_stall_req, if_pc, if_inst} !== {1'b0, 17'd0, 32'h00500013}) begin
            errors++; $display("FAIL gap_word: stall=%b pc=%h inst=%h want 0/0/00500013", if_stall_req, if_pc, if_inst);
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        repeat (5) @(negedge clk);
        stall_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({if_stall_req, mem_req, if_pc, if_inst} !== {1'b0, 1'b0, 17'd0, 32'h00500013}) begin
                errors++;
                $display("FAIL hold%0d: stall=%b req=%b pc=%h inst=%h want 0/0/0/00500013", i, if_stall_req, mem_req, if_pc, if_inst);
            end
        end
        stall_hold = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, if_stall_req} !== {1'b1, 17'd4, 1'b1}) begin
            errors++; $display("FAIL hold_release: req=%b addr=%h stall=%b want 1/4/1", mem_req, mem_addr, if_stall_req);
        end
    endtask

    task automatic test_redirect_mid_fetch();
        do_reset();
        repeat (3) @(negedge clk);
        br_taken = 1'b1; br_addr = 17'h00100;
        @(negedge clk);
        br_taken = 1'b0;
        checks++;
        if ({mem_req, mem_addr, if_stall_req} !== {1'b1, 17'h00100, 1'b1}) begin
            errors++; $display("FAIL redir_addr: req=%b addr=%h stall=%b want 1/00100/1", mem_req, mem_addr, if_stall_req);
        end
        wait_word(8);
        checks++;
        if ({if_pc, if_inst} !== {17'h00100, 32'h5D5C5B5A}) begin
            errors++; $display("FAIL redir_word: pc=%h inst=%h want 00100/5d5c5b5a", if_pc, if_inst);
        end
    endtask

    task automatic test_redirect_in_done();
        do_reset();
        repeat (5) @(negedge clk);
        stall_hold = 1'b1;
        @(negedge clk);
        br_taken = 1'b1; br_addr = 17'h00100;
        @(negedge clk);
        br_taken = 1'b0; stall_hold = 1'b0;
        checks++;
        if ({mem_req, mem_addr, if_stall_req, if_inst} !== {1'b1, 17'h00100, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL done_redir: req=%b addr=%h stall=%b inst=%h want 1/00100/1/0", mem_req, mem_addr, if_stall_req, if_inst);
        end
        wait_word(8);
        checks++;
        if ({if_pc, if_inst} !== {17'h00100, 32'h5D5C5B5A}) begin
            errors++; $display("FAIL done_redir_word: pc=%h inst=%h want 00100/5d5c5b5a", if_pc, if_inst);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        br_taken = 1'b1; br_addr = 17'h1FFFC;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            br_taken = 1'b0;
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, 17'h1FFFC + 17'(i)}) begin
                errors++; $display("FAIL wrap_addr%0d: req=%b addr=%h want 1/%h", i, mem_req, mem_addr, 17'h1FFFC + 17'(i));
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({if_stall_req, if_pc, if_inst} !== {1'b0, 17'h1FFFC, 32'h59585756}) begin
            errors++; $display("FAIL wrap_word: stall=%b pc=%h inst=%h want 0/1fffc/59585756", if_stall_req, if_pc, if_inst);
        end
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, if_pc} !== {1'b1, 17'd0, 17'd0}) begin
            errors++; $display("FAIL wrap_next: req=%b addr=%h pc=%h want 1/0/0", mem_req, mem_addr, if_pc);
        end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL freeze_req: got %b want 0", mem_req); end
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, if_stall_req} !== {1'b0, 17'd1, 1'b1}) begin
            errors++; $display("FAIL freeze_hold: req=%b addr=%h stall=%b want 0/1/1", mem_req, mem_addr, if_stall_req);
        end
        rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 17'd2}) begin
            errors++; $display("FAIL freeze_resume: req=%b addr=%h want 1/2", mem_req, mem_addr);
        end
        wait_word(8);
        checks++;
        if ({if_pc, if_inst} !== {17'd0, 32'h00500013}) begin
            errors++; $display("FAIL freeze_word: pc=%h inst=%h want 0/00500013", if_pc, if_inst);
        end
    endtask

`ifdef IF_ICACHE_EN
    task automatic test_icache();
        do_reset();
        wait_word(8);
        checks++;
        if ({if_pc, if_inst} !== {17'd0, 32'h00500013}) begin
            errors++; $display("FAIL ic_first: pc=%h inst=%h want 0/00500013", if_pc, if_inst);
        end
        br_taken = 1'b1; br_addr = 17'd8;
        @(negedge clk);
        br_taken = 1'b0;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 17'd8}) begin
            errors++; $display("FAIL ic_miss: req=%b addr=%h want 1/8", mem_req, mem_addr);
        end
        wait_word(8);
        checks++;
        if ({if_pc, if_inst} !== {17'd8, 32'h65646362}) begin
            errors++; $display("FAIL ic_word8: pc=%h inst=%h want 8/65646362", if_pc, if_inst);
        end
        br_taken = 1'b1; br_addr = 17'd0;
        @(negedge clk);
        br_taken = 1'b0;
        checks++;
        if ({mem_req, if_stall_req} !== 2'b01) begin
            errors++; $display("FAIL ic_hit_req: req=%b stall=%b want 0/1", mem_req, if_stall_req);
        end
        @(negedge clk);
        checks++;
        if ({mem_req, if_stall_req, if_pc, if_inst} !== {1'b0, 1'b0, 17'd0, 32'h00500013}) begin
            errors++;
            $display("FAIL ic_hit_word: req=%b stall=%b pc=%h inst=%h want 0/0/0/00500013", mem_req, if_stall_req, if_pc, if_inst);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_fetch();
        test_basic_fetch();
        test_grant_gaps();
        test_stall_hold();
        test_redirect_mid_fetch();
        test_redirect_in_done();
        test_wrap();
        test_rdy_freeze();
`ifdef IF_ICACHE_EN
        test_icache();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
